// File: rtl/jtopl_logsin_arb.sv
// Round-robin arbiter sharing one registered log-sine ROM among NREQ phase requesters.
// Optional OPL2 waveform select/mute path enabled by JTOPL_LOGSIN_ARB_WAVE_EN.
module jtopl_logsin_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*10-1:0] phase,
`ifdef JTOPL_LOGSIN_ARB_WAVE_EN
    input  logic [NREQ*2-1:0] ws,
    output logic              out_mute,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        rom_addr,
    input  logic [11:0]       rom_data,
    output logic              out_valid,
    output logic [IDW-1:0]    out_id,
    output logic [11:0]       out_logsin,
    output logic              out_sign
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [7:0]     rom_addr_q, rom_addr_d;
    logic           s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [IDW-1:0] s1_id_q, s1_id_d, s2_id_q, s2_id_d;
    logic           s1_sign_q, s1_sign_d, s2_sign_q, s2_sign_d;
    logic           s1_mute_q, s1_mute_d, s2_mute_q, s2_mute_d;
    logic           out_valid_q, out_valid_d;
    logic [IDW-1:0] out_id_q, out_id_d;
    logic [11:0]    out_logsin_q, out_logsin_d;
    logic           out_sign_q, out_sign_d;
    logic           out_mute_q, out_mute_d;

    logic           grant;
    logic [IDW-1:0] gidx;
    logic [9:0]     sel_ph;
    logic [1:0]     sel_ws;
    logic [7:0]     fold;
    logic           req_sign;
    logic           req_mute;
    int             j;

    always_comb begin
        grant = 1'b0;
        gidx  = '0;
        j     = 0;
        // search starts one past the last winner
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (!grant && req[j]) begin
                grant = 1'b1;
                gidx  = IDW'(j);
            end
        end
        grant = grant & cen;
        gnt   = '0;
        if (grant) gnt[gidx] = 1'b1;

        sel_ph = phase[int'(gidx)*10 +: 10];
        fold   = sel_ph[8] ? ~sel_ph[7:0] : sel_ph[7:0];
`ifdef JTOPL_LOGSIN_ARB_WAVE_EN
        sel_ws = ws[int'(gidx)*2 +: 2];
`else
        sel_ws = 2'd0;
`endif
        req_sign = 1'b0;
        req_mute = 1'b0;
        unique case (sel_ws)
            2'd0: req_sign = sel_ph[9];
            2'd1: req_mute = sel_ph[9];
            2'd2: req_mute = 1'b0;
            2'd3: req_mute = sel_ph[8];
        endcase

        ptr_d        = ptr_q;
        rom_addr_d   = rom_addr_q;
        s1_v_d       = s1_v_q;
        s1_id_d      = s1_id_q;
        s1_sign_d    = s1_sign_q;
        s1_mute_d    = s1_mute_q;
        s2_v_d       = s2_v_q;
        s2_id_d      = s2_id_q;
        s2_sign_d    = s2_sign_q;
        s2_mute_d    = s2_mute_q;
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        out_logsin_d = out_logsin_q;
        out_sign_d   = out_sign_q;
        out_mute_d   = out_mute_q;

        if (cen) begin
            s1_v_d = grant;
            if (grant) begin
                ptr_d      = gidx;
                rom_addr_d = fold;
                s1_id_d    = gidx;
                s1_sign_d  = req_sign;
                s1_mute_d  = req_mute;
            end
            s2_v_d      = s1_v_q;
            s2_id_d     = s1_id_q;
            s2_sign_d   = s1_sign_q;
            s2_mute_d   = s1_mute_q;
            out_valid_d = s2_v_q;
            if (s2_v_q) begin
                out_logsin_d = rom_data;
                out_id_d     = s2_id_q;
                out_sign_d   = s2_sign_q;
                out_mute_d   = s2_mute_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= IDW'(NREQ - 1);
            rom_addr_q   <= '0;
            s1_v_q       <= 1'b0;
            s1_id_q      <= '0;
            s1_sign_q    <= 1'b0;
            s1_mute_q    <= 1'b0;
            s2_v_q       <= 1'b0;
            s2_id_q      <= '0;
            s2_sign_q    <= 1'b0;
            s2_mute_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_logsin_q <= '0;
            out_sign_q   <= 1'b0;
            out_mute_q   <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            rom_addr_q   <= rom_addr_d;
            s1_v_q       <= s1_v_d;
            s1_id_q      <= s1_id_d;
            s1_sign_q    <= s1_sign_d;
            s1_mute_q    <= s1_mute_d;
            s2_v_q       <= s2_v_d;
            s2_id_q      <= s2_id_d;
            s2_sign_q    <= s2_sign_d;
            s2_mute_q    <= s2_mute_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_logsin_q <= out_logsin_d;
            out_sign_q   <= out_sign_d;
            out_mute_q   <= out_mute_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign out_valid  = out_valid_q;
    assign out_id     = out_id_q;
    assign out_logsin = out_logsin_q;
    assign out_sign   = out_sign_q;
`ifdef JTOPL_LOGSIN_ARB_WAVE_EN
    assign out_mute   = out_mute_q;
`endif

endmodule
